// File: rtl/du_core_router.sv
// du_core_router: fans one host debug-unit port out to NUM_CORES per-core debug ports
module du_core_router #(
    parameter int          NUM_CORES = 2,
    parameter int          SEL_W     = 4,
    parameter logic [31:0] SEL_ADDR  = 32'hFFFF_FF00,
    parameter int          TIMEOUT   = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic [31:0]               du_addr_i,
    input  logic [31:0]               du_dat_i,
    input  logic                      du_we_i,
    input  logic                      du_stb_i,
    output logic [31:0]               du_dat_o,
    output logic                      du_ack_o,
    input  logic                      du_stall_i,
    output logic                      du_bp_o,
    output logic                      du_timeout_o,
    output logic [32*NUM_CORES-1:0]   core_addr_o,
    output logic [32*NUM_CORES-1:0]   core_dat_o,
    output logic [NUM_CORES-1:0]      core_we_o,
    output logic [NUM_CORES-1:0]      core_stb_o,
    input  logic [32*NUM_CORES-1:0]   core_dat_i,
    input  logic [NUM_CORES-1:0]      core_ack_i,
    output logic [NUM_CORES-1:0]      core_stall_o,
    input  logic [NUM_CORES-1:0]      core_bp_i
);
    typedef enum logic [2:0] {S_IDLE, S_LOCAL, S_FWD, S_ACK, S_WAITLOW} state_t;

    state_t                r_state, w_next;
    logic [SEL_W-1:0]      r_sel, r_tgt;
    logic [NUM_CORES-1:0]  r_bp_seen, w_oh;
    logic                  r_to_flag, r_we, r_bp, r_timeout;
    logic [31:0]           r_addr, r_dat, r_dat_o, w_status, w_rdata;
    logic [15:0]           r_cnt;
    logic                  w_fwd, w_local, w_ack, w_to, w_start, w_clr, w_sel_ok;

    assign w_fwd    = r_state == S_FWD;
    assign w_local  = r_state == S_LOCAL;
    assign w_ack    = |(core_ack_i & w_oh);
    assign w_to     = w_fwd && !w_ack && r_cnt == 16'(TIMEOUT - 1);
    assign w_start  = r_state == S_IDLE && du_stb_i && du_addr_i != SEL_ADDR;
    assign w_clr    = w_local && du_we_i && du_dat_i[31];
    assign w_sel_ok = 32'(du_dat_i[SEL_W-1:0]) < 32'(NUM_CORES);

    // Only the latched target sees the transfer; every other slice is held at zero
    for (genvar n = 0; n < NUM_CORES; n++) begin : g_core
        assign w_oh[n]                = r_tgt == SEL_W'(n);
        assign core_addr_o[32*n +: 32] = (w_fwd && w_oh[n]) ? r_addr : 32'h0;
        assign core_dat_o[32*n +: 32]  = (w_fwd && w_oh[n]) ? r_dat : 32'h0;
    end

    assign core_stb_o   = w_fwd ? w_oh : '0;
    assign core_we_o    = (w_fwd && r_we) ? w_oh : '0;
    assign core_stall_o = {NUM_CORES{du_stall_i}};

    assign du_dat_o     = r_dat_o;
    assign du_ack_o     = r_state == S_ACK;
    assign du_bp_o      = r_bp;
    assign du_timeout_o = r_timeout;

    // Read data mux from the target core
    always_comb begin
        w_rdata = 32'h0;
        for (int i = 0; i < NUM_CORES; i++)
            w_rdata = w_rdata | (w_oh[i] ? core_dat_i[32*i +: 32] : 32'h0);
    end

    // Status word: breakpoint history high, sticky timeout at bit 15, core select low
    always_comb begin
        w_status                   = 32'h0;
        w_status[16 +: NUM_CORES]  = r_bp_seen;
        w_status[15]               = r_to_flag;
        w_status[SEL_W-1:0]        = r_sel;
    end

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    // Next-state logic; the host must drop strobe before a new transfer is accepted
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (du_stb_i) begin
                    if (du_addr_i == SEL_ADDR) w_next = S_LOCAL;
                    else                       w_next = S_FWD;
                end
            end
            S_LOCAL:   w_next = S_ACK;
            S_FWD:     if (w_ack || w_to) w_next = S_ACK;
            S_ACK:     w_next = S_WAITLOW;
            S_WAITLOW: if (!du_stb_i) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath: select/status registers, transfer latches, timeout counter and host read data
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_sel     <= '0;
            r_tgt     <= '0;
            r_bp_seen <= '0;
            r_to_flag <= 1'b0;
            r_we      <= 1'b0;
            r_bp      <= 1'b0;
            r_timeout <= 1'b0;
            r_addr    <= 32'h0;
            r_dat     <= 32'h0;
            r_dat_o   <= 32'h0;
            r_cnt     <= 16'h0;
        end else begin
            r_sel     <= (w_local && du_we_i && w_sel_ok) ? du_dat_i[SEL_W-1:0] : r_sel;
            r_bp_seen <= (w_clr ? '0 : r_bp_seen) | core_bp_i;
            r_to_flag <= w_to | (r_to_flag & !w_clr);
            r_bp      <= |core_bp_i;
            r_timeout <= w_to;
            r_cnt     <= w_fwd ? r_cnt + 16'd1 : 16'd0;
            if (w_start) begin
                r_addr <= du_addr_i;
                r_dat  <= du_dat_i;
                r_we   <= du_we_i;
                r_tgt  <= r_sel;
            end
            r_dat_o   <= w_local ? (du_we_i ? 32'h0 : w_status) :
                         (w_fwd && w_ack) ? (r_we ? 32'h0 : w_rdata) :
                         w_to ? 32'hDEAD_DEAD : r_dat_o;
        end
    end
endmodule
